// File: rtl/aes_io_pkg.sv
// aes_io_pkg
// Shared definitions for the io_module link initiator:
//   - command / response encodings on the 2-bit handshake signals
//   - word counts for the write (message + key) and read (plaintext) phases
//   - host FSM state type and small decode helpers
package aes_io_pkg;

    // Command driven towards io_module (to_hw_sig). 2'b11 is never produced.
    typedef enum logic [1:0] {
        CMD_IDLE  = 2'b00,
        CMD_WRITE = 2'b01,
        CMD_READ  = 2'b10
    } cmd_e;

    // Response returned by io_module (to_sw_sig).
    typedef enum logic [1:0] {
        RSP_IDLE = 2'b00,
        RSP_ACK  = 2'b01,
        RSP_DATA = 2'b10
    } rsp_e;

    localparam int WORD_W     = 32;
    localparam int N_WR_WORDS = 8;   // 4 message words followed by 4 key words
    localparam int N_RD_WORDS = 4;   // 4 decrypted message words

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_REQ,
        S_W_REL,
        S_R_REQ,
        S_R_REL,
        S_DONE,
        S_ERR
    } state_e;

    // Command presented on the link while the FSM sits in a given state.
    function automatic logic [1:0] state_cmd(input state_e s);
        case (s)
            S_W_REQ: return CMD_WRITE;
            S_R_REQ: return CMD_READ;
            default: return CMD_IDLE;
        endcase
    endfunction

    // States in which the host is waiting on the responder.
    function automatic logic state_waiting(input state_e s);
        return (s == S_W_REQ) || (s == S_W_REL) || (s == S_R_REQ) || (s == S_R_REL);
    endfunction

endpackage

// File: rtl/aes_io_host_timeout.sv
// io_timeout_ctr
// Loadable saturating wait counter with a limit comparator.
//   clk, reset_n   : clock, asynchronous active-low reset
//   i_clr          : force the count to zero next cycle (highest priority)
//   i_load         : load i_load_val next cycle
//   i_en           : count one more waited cycle (saturates at all-ones)
//   i_limit        : number of waited cycles allowed (must be >= 1)
//   o_hit          : the current cycle is the last allowed waiting cycle
module io_timeout_ctr #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_hit
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    // r_count holds the cycles already waited before this one, so the
    // limit-th waiting cycle is the one where r_count == limit-1.
    assign o_hit = (r_count >= (i_limit - WIDTH'(1)));

endmodule

// File: rtl/aes_io_host.sv
// aes_io_host
// Hardware initiator for the io_module 2-bit-signal / 32-bit-port link.
// Sends a 128-bit ciphertext and a 128-bit key (eight 32-bit writes, MSW
// first), then reads back four 32-bit words of decrypted message.
//   clk, reset_n      : clock, asynchronous active-low reset
//   start             : one-cycle pulse, accepted in IDLE or ERR
//   msg_en_in, key_in : ciphertext and key, latched on an accepted start
//   to_hw_sig/port    : command and write data towards io_module
//   to_sw_sig/port    : response and read data from io_module
//   msg_de_out        : decrypted message, word 0 in [127:96]
//   busy              : transaction in progress
//   done              : one-cycle completion pulse
//   err               : sticky handshake timeout, cleared by next start
module aes_io_host
    import aes_io_pkg::*;
#(
    parameter int WR_TIMEOUT = 1024,
    parameter int RD_TIMEOUT = 65536
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] msg_en_in,
    input  logic [127:0] key_in,
    output logic [1:0]   to_hw_sig,
    output logic [31:0]  to_hw_port,
    input  logic [1:0]   to_sw_sig,
    input  logic [31:0]  to_sw_port,
    output logic [127:0] msg_de_out,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int MAX_TMO = (WR_TIMEOUT > RD_TIMEOUT) ? WR_TIMEOUT : RD_TIMEOUT;
    localparam int TW      = $clog2(MAX_TMO + 1);
    localparam logic [TW-1:0] WR_LIM  = TW'(WR_TIMEOUT);
    localparam logic [TW-1:0] RD_LIM  = TW'(RD_TIMEOUT);
    localparam logic [3:0]    WR_LAST = 4'(N_WR_WORDS - 1);
    localparam logic [3:0]    RD_LAST = 4'(N_RD_WORDS - 1);

    state_e         r_state;
    state_e         w_state_next;
    logic [255:0]   r_buf;          // top word is the word on the link
    logic [3:0]     r_word_cnt;
    logic [1:0]     r_to_hw_sig;
    logic [31:0]    r_rd_word [N_RD_WORDS];
    logic           r_busy;
    logic           r_done;
    logic           r_err;

    logic           w_start_ok;
    logic           w_rsp_ack;
    logic           w_rsp_data;
    logic           w_rsp_idle;
    logic           w_capture;
    logic           w_tmo_hit;
    logic           w_tmo_clr;
    logic [TW-1:0]  w_tmo_limit;

    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_ERR));
    assign w_rsp_ack   = (to_sw_sig == RSP_ACK);
    assign w_rsp_data  = (to_sw_sig == RSP_DATA);
    assign w_rsp_idle  = (to_sw_sig == RSP_IDLE);
    assign w_capture   = (r_state == S_R_REQ) && w_rsp_data;

    // Every state change restarts the wait count from zero.
    assign w_tmo_clr   = (w_state_next != r_state);
    assign w_tmo_limit = (r_state == S_R_REQ) ? RD_LIM : WR_LIM;

    io_timeout_ctr #(
        .WIDTH (TW)
    ) u_tmo (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clr      (w_tmo_clr),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (state_waiting(r_state)),
        .i_limit    (w_tmo_limit),
        .o_hit      (w_tmo_hit)
    );

    // ------------------------------------------------------------------
    // FSM: state register and next-state logic. A qualifying response
    // always wins over a timeout falling in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_W_REQ;
            end
            S_W_REQ: begin
                if (w_rsp_ack)      w_state_next = S_W_REL;
                else if (w_tmo_hit) w_state_next = S_ERR;
            end
            S_W_REL: begin
                if (w_rsp_idle)     w_state_next = (r_word_cnt == WR_LAST) ? S_R_REQ : S_W_REQ;
                else if (w_tmo_hit) w_state_next = S_ERR;
            end
            S_R_REQ: begin
                if (w_rsp_data)     w_state_next = S_R_REL;
                else if (w_tmo_hit) w_state_next = S_ERR;
            end
            S_R_REL: begin
                if (w_rsp_idle)     w_state_next = (r_word_cnt == RD_LAST) ? S_DONE : S_R_REQ;
                else if (w_tmo_hit) w_state_next = S_ERR;
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            S_ERR: begin
                if (start) w_state_next = S_W_REQ;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs, shift buffer and word counter. Outputs are
    // computed from the next state so they line up with r_state without
    // any combinational decode on the pins.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf       <= '0;
            r_word_cnt  <= '0;
            r_to_hw_sig <= CMD_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_to_hw_sig <= state_cmd(w_state_next);
            r_busy      <= state_waiting(w_state_next);
            r_done      <= (w_state_next == S_DONE);

            if (w_state_next == S_ERR) begin
                r_err <= 1'b1;
            end

            if (w_start_ok) begin
                r_buf      <= {msg_en_in, key_in};
                r_word_cnt <= '0;
                r_err      <= 1'b0;
            end

            case (r_state)
                S_W_REL: begin
                    if (w_rsp_idle) begin
                        // Advance to the next word only once the responder
                        // has released, so the port is stable per word.
                        r_buf      <= {r_buf[223:0], 32'h0};
                        r_word_cnt <= (r_word_cnt == WR_LAST) ? 4'd0 : r_word_cnt + 4'd1;
                    end
                end
                S_R_REL: begin
                    if (w_rsp_idle) begin
                        r_word_cnt <= (r_word_cnt == RD_LAST) ? 4'd0 : r_word_cnt + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Read capture: one register per plaintext word, written only on the
    // R_REQ cycle in which the responder presents data.
    for (genvar gi = 0; gi < N_RD_WORDS; gi++) begin : g_rd_slot
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_rd_word[gi] <= '0;
            end else if (w_capture && (r_word_cnt == 4'(gi))) begin
                r_rd_word[gi] <= to_sw_port;
            end
        end
        assign msg_de_out[127 - WORD_W*gi -: WORD_W] = r_rd_word[gi];
    end

    assign to_hw_sig  = r_to_hw_sig;
    assign to_hw_port = r_buf[255:224];
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_aes_io_host.sv
// tb_aes_io_host
// Scoreboard bench for aes_io_host. A responder model answers the link;
// stimulus pushes expected write words and transaction results into
// queues, and a negedge monitor pops and compares them as the DUT
// presents write words, done pulses and error entries.
module tb_aes_io_host;

    localparam int WR_TMO = 1024;
    localparam int RD_TMO = 4096;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] msg_en_in = '0;
    logic [127:0] key_in = '0;
    logic [1:0]   to_hw_sig;
    logic [31:0]  to_hw_port;
    logic [1:0]   to_sw_sig;
    logic [31:0]  to_sw_port;
    logic [127:0] msg_de_out;
    logic         busy, done, err;

    always #5 clk = ~clk;

    aes_io_host #(
        .WR_TIMEOUT (WR_TMO),
        .RD_TIMEOUT (RD_TMO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .msg_en_in  (msg_en_in),
        .key_in     (key_in),
        .to_hw_sig  (to_hw_sig),
        .to_hw_port (to_hw_port),
        .to_sw_sig  (to_sw_sig),
        .to_sw_port (to_sw_port),
        .msg_de_out (msg_de_out),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    int n_total = 0;
    int n_pass  = 0;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endfunction

    // ---------------- responder model (zero latency unless told) -------
    int          wr_idx = 0, rd_idx = 0, stall_cnt = 0;
    int          drop_word = -1, stall_word = -1, stall_target = 0;
    logic [31:0] rd_data [4];

    always_comb begin
        to_sw_sig  = 2'b00;
        to_sw_port = 32'h0;
        case (to_hw_sig)
            2'b01: if (wr_idx != drop_word) to_sw_sig = 2'b01;
            2'b10: if (rd_idx < 4 && (rd_idx != stall_word || stall_cnt >= stall_target)) begin
                to_sw_sig  = 2'b10;
                to_sw_port = rd_data[rd_idx[1:0]];
            end
            default: ;
        endcase
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic         is_err;
        logic [127:0] msg;
    } res_t;

    logic [31:0] exp_wr_q [$];
    res_t        exp_res_q [$];

    logic [1:0]  prev_hw = 2'b00;
    logic [31:0] prev_port = 32'h0;
    logic        prev_err = 1'b0, prev_done = 1'b0;
    int          viol = 0;

    always @(negedge clk) begin
        res_t e;
        if (to_hw_sig == 2'b11) viol++;
        if (to_hw_sig == 2'b01 && prev_hw == 2'b01 && to_hw_port != prev_port) viol++;
        if (prev_hw == 2'b01 && to_hw_sig == 2'b00 && reset_n && to_hw_port != prev_port) viol++;
        if (done && prev_done) viol++;

        if (to_hw_sig == 2'b01 && prev_hw != 2'b01) begin
            if (exp_wr_q.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
                $display("wr word %h", to_hw_port);
                chk("wr_word", to_hw_port, exp_wr_q.pop_front());
            end
        end
        if (prev_hw == 2'b01 && to_hw_sig != 2'b01) wr_idx++;
        if (prev_hw == 2'b10 && to_hw_sig != 2'b10) rd_idx++;
        stall_cnt = (to_hw_sig == 2'b10) ? stall_cnt + 1 : 0;

        if (done && !prev_done) begin
            $display("done msg_de_out=%h", msg_de_out);
            if (exp_res_q.size() == 0) chk("done_unexpected", 1, 0);
            else begin
                e = exp_res_q.pop_front();
                chk("res_kind_done", 0, e.is_err);
                chk("done_msg", msg_de_out, e.msg);
                chk("done_err", err, 0);
                chk("done_busy", busy, 0);
            end
        end
        if (err && !prev_err) begin
            $display("err msg_de_out=%h", msg_de_out);
            if (exp_res_q.size() == 0) chk("err_unexpected", 1, 0);
            else begin
                e = exp_res_q.pop_front();
                chk("res_kind_err", 1, e.is_err);
                chk("err_msg", msg_de_out, e.msg);
                chk("err_busy", busy, 0);
                chk("err_hw_sig", to_hw_sig, 0);
            end
        end
        prev_hw   = to_hw_sig;
        prev_port = to_hw_port;
        prev_err  = err;
        prev_done = done;
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_words(input logic [127:0] m, input logic [127:0] k, input int n);
        logic [255:0] b;
        b = {m, k};
        for (int i = 0; i < n; i++) exp_wr_q.push_back(b[255 - 32*i -: 32]);
    endtask

    task automatic push_res(input logic is_err, input logic [127:0] m);
        res_t r;
        r.is_err = is_err;
        r.msg    = m;
        exp_res_q.push_back(r);
    endtask

    task automatic set_rd(input logic [127:0] d);
        for (int i = 0; i < 4; i++) rd_data[i] = d[127 - 32*i -: 32];
    endtask

    task automatic pulse_start();
        @(negedge clk);
        wr_idx = 0;
        rd_idx = 0;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 10000) begin
            @(negedge clk);
            n++;
        end
        chk(name, busy, 0);
        repeat (2) @(negedge clk);
    endtask

    // Counts R_REQ/W_REQ cycles of the selected word until err rises.
    task automatic time_err(input string name, input logic [1:0] sig, input int idx, input int exp_n);
        int n;
        n = 0;
        while (!(to_hw_sig == sig && (sig == 2'b01 ? wr_idx : rd_idx) == idx) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        n = 1;
        while (!err && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk(name, n, exp_n);
    endtask

    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

    initial begin
        int n;
        logic [1:0] ph;
        logic [31:0] fips_words [8];
        fips_words = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a,
                       32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_hw_sig", to_hw_sig, 0);
        chk("rst_hw_port", to_hw_port, 0);
        chk("rst_msg_de", msg_de_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // T1: FIPS-197 vector, zero-latency responder, start->done latency
        $display("T1 fips zero-latency");
        msg_en_in = FIPS_CT;
        key_in    = FIPS_KEY;
        set_rd(FIPS_PT);
        for (int i = 0; i < 8; i++) exp_wr_q.push_back(fips_words[i]);
        push_res(1'b0, FIPS_PT);
        pulse_start();
        chk("t1_busy", busy, 1);
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        chk("t1_latency", n, 24);
        wait_idle("t1_idle");

        // T2: read data for word 2 first offered on the last allowed cycle
        $display("T2 read stall at limit");
        msg_en_in = 128'h00000000111111112222222233333333;
        key_in    = 128'h44444444555555556666666677777777;
        set_rd(128'h0123456789abcdeffedcba9876543210);
        stall_word   = 2;
        stall_target = RD_TMO;
        push_words(msg_en_in, key_in, 8);
        push_res(1'b0, 128'h0123456789abcdeffedcba9876543210);
        pulse_start();
        wait_idle("t2_idle");

        // T3: one cycle too late -> timeout, partial capture kept
        $display("T3 read timeout");
        set_rd(128'ha0a0a0a0b1b1b1b1c2c2c2c2d3d3d3d3);
        stall_target = RD_TMO + 1;
        push_words(msg_en_in, key_in, 8);
        push_res(1'b1, 128'ha0a0a0a0b1b1b1b1fedcba9876543210);
        pulse_start();
        time_err("t3_err_cycle", 2'b10, 2, RD_TMO + 1);
        @(negedge clk);
        chk("t3_err_sticky", err, 1);
        stall_word = -1;

        // T4: write ack for word 2 never arrives; start from ERR clears err
        $display("T4 write ack loss");
        drop_word = 2;
        msg_en_in = FIPS_CT;
        key_in    = FIPS_KEY;
        push_words(msg_en_in, key_in, 3);
        push_res(1'b1, 128'ha0a0a0a0b1b1b1b1fedcba9876543210);
        pulse_start();
        chk("t4_err_cleared", err, 0);
        time_err("t4_err_cycle", 2'b01, 2, WR_TMO + 1);
        @(negedge clk);
        chk("t4_busy", busy, 0);
        drop_word = -1;

        // T5: clean FIPS transaction after an error
        $display("T5 fips after error");
        set_rd(FIPS_PT);
        push_words(FIPS_CT, FIPS_KEY, 8);
        push_res(1'b0, FIPS_PT);
        pulse_start();
        wait_idle("t5_idle");
        chk("t5_err", err, 0);

        // T6: start pulse at word 5 ignored, key change does not leak
        $display("T6 start during busy");
        set_rd(128'h11111111222222223333333344444444);
        push_words(FIPS_CT, FIPS_KEY, 8);
        push_res(1'b0, 128'h11111111222222223333333344444444);
        pulse_start();
        n = 0;
        while (!(to_hw_sig == 2'b01 && wr_idx == 5) && n < 100) begin
            @(negedge clk);
            n++;
        end
        start  = 1'b1;
        key_in = 128'hffffffffeeeeeeeeddddddddcccccccc;
        @(posedge clk);
        #1 start = 1'b0;
        chk("t6_busy", busy, 1);
        wait_idle("t6_idle");
        repeat (20) @(negedge clk);
        chk("t6_no_restart_busy", busy, 0);
        chk("t6_no_restart_sig", to_hw_sig, 0);

        // T7: reset in R_REL -> outputs cleared asynchronously
        $display("T7 reset in R_REL");
        key_in = FIPS_KEY;
        set_rd(FIPS_PT);
        push_words(FIPS_CT, FIPS_KEY, 8);
        pulse_start();
        ph = 2'b00;
        n  = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (to_hw_sig == 2'b00 && ph == 2'b10 && busy) break;
            ph = to_hw_sig;
        end
        reset_n = 1'b0;
        #1;
        chk("t7_hw_sig", to_hw_sig, 0);
        chk("t7_hw_port", to_hw_port, 0);
        chk("t7_msg_de", msg_de_out, 0);
        chk("t7_busy", busy, 0);
        chk("t7_done", done, 0);
        chk("t7_err", err, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // T8: clean transaction after reset
        $display("T8 after reset");
        msg_en_in = 128'hffeeddccbbaa99887766554433221100;
        key_in    = 128'h0f0e0d0c0b0a09080706050403020100;
        set_rd(128'hcafef00d123456789abcdef00badc0de);
        push_words(msg_en_in, key_in, 8);
        push_res(1'b0, 128'hcafef00d123456789abcdef00badc0de);
        pulse_start();
        wait_idle("t8_idle");

        chk("wr_queue_empty", exp_wr_q.size(), 0);
        chk("res_queue_empty", exp_res_q.size(), 0);
        chk("protocol_violations", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
